alu_pipe: RTL

Parametrised, handshaked successor to the team's combinational 8-op ALU. It accepts one operation per cycle on a valid/ready input port and registers the result and a full flag set on a valid/ready output port. It adds variable shifts, signed/unsigned compares and an iterative shift-add multiplier. It sits between the operand-fetch stage and writeback, and absorbs writeback backpressure without losing results.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_mul_iter.sv | 53 +++++
 rtl/alu_pipe.sv | 135 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcodes, FSM states and the flag bundle.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;
  localparam int unsigned MUL_LAT   = ALU_WIDTH;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOT  = 4'd5,
    OP_SLL  = 4'd6,
    OP_SRL  = 4'd7,
    OP_SRA  = 4'd8,
    OP_SLT  = 4'd9,
    OP_SLTU = 4'd10,
    OP_MUL  = 4'd11
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_e;

  typedef struct packed {
    logic err;
    logic ovf;
    logic carry;
    logic neg;
    logic zero;
  } alu_flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per step, fixed WIDTH steps.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done_c,
  output logic [WIDTH-1:0] product_c
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_nxt;

  always_comb begin
    acc_nxt = acc;
    if (mplier[0]) acc_nxt = acc + mcand;
  end

  // The final partial product is folded in combinationally so the result lands on the last step edge.
  assign product_c = acc_nxt;
  assign done_c    = step && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (step) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle ops register on accept, MUL runs iteratively, output slot absorbs backpressure.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output alu_flags_t       flags,
  output logic             busy
);

  localparam int unsigned SHW = $clog2(WIDTH);

  alu_state_e       state;
  alu_state_e       state_nxt;
  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH:0]   add_full;
  logic [WIDTH-1:0] sub_res;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  alu_flags_t       alu_flags;
  logic             load;
  logic [WIDTH-1:0] ld_result;
  alu_flags_t       ld_flags;

  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == OP_MUL);
  assign shamt     = b[SHW-1:0];
  assign add_full  = {1'b0, a} + {1'b0, b};
  assign sub_res   = a - b;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (mul_start),
    .step      (state == MUL),
    .a         (a),
    .b         (b),
    .done_c    (mul_done),
    .product_c (mul_product)
  );

  // Single-cycle op decode and flags.
  always_comb begin
    alu_res   = '0;
    alu_flags = '0;
    unique case (op)
      OP_ADD: begin
        alu_res         = add_full[WIDTH-1:0];
        alu_flags.carry = add_full[WIDTH];
        alu_flags.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res         = sub_res;
        alu_flags.carry = (a >= b);
        alu_flags.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOT:  alu_res = ~a;
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = WIDTH'($signed(a) >>> shamt);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_MUL:  alu_res = '0;
      default: alu_flags.err = 1'b1;
    endcase
    alu_flags.zero = (alu_res == '0);
    alu_flags.neg  = alu_res[WIDTH-1];
  end

  always_comb begin
    ld_result      = alu_res;
    ld_flags       = alu_flags;
    load           = accept && (op != OP_MUL);
    if (mul_done) begin
      load           = 1'b1;
      ld_result      = mul_product;
      ld_flags       = '0;
      ld_flags.zero  = (mul_product == '0);
      ld_flags.neg   = mul_product[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (mul_start) state_nxt = MUL;
      MUL:     if (mul_done)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    if (state == IDLE) in_ready = !out_valid || out_ready;
    if (state == MUL)  busy = 1'b1;
  end

  // Output slot: a load always wins over a simultaneous pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      result    <= ld_result;
      flags     <= ld_flags;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
